// File: rtl/act_mem_pkg.sv
// Shared types and defaults for the activation-memory external-port arbiter.
package act_mem_pkg;

    localparam int unsigned ACT_ADDR_W      = 16;
    localparam int unsigned ACT_DATA_W      = 64;
    localparam int unsigned ACT_STALL_CNT_W = 16;

    // Response-slot FSM: a read occupies the slot from grant until the response is taken.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } arb_state_t;

    // Requester index: 0 = host loader, 1 = host read-back.
    typedef logic req_id_t;

    // Address bit that selects 32K half-bank 0/1.
    function automatic int unsigned half_msb(input int unsigned addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/act_mem_ext_arbiter_rr.sv
// Two-way round-robin arbiter with an eligibility mask; port 0 wins the first tie.
import act_mem_pkg::*;

module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] grant,
    output logic       grant_any,
    output req_id_t    grant_id
);

    req_id_t rr_last;

    // Pick the winner: alternate on a tie, otherwise the only eligible port.
    always_comb begin
        grant_any = |eligible;
        grant_id  = 1'b0;
        if (eligible == 2'b11) begin
            grant_id = ~rr_last;
        end else if (eligible[1]) begin
            grant_id = 1'b1;
        end
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Remember the last granted port; reset value makes port 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (grant_any) begin
            rr_last <= grant_id;
        end
    end

endmodule

// File: rtl/act_mem_ext_arbiter.sv
// Shares the activation memory external port between the host loader (port 0) and
// host read-back (port 1), blocking the half-bank(s) the MAC engine is using.
// Optional perf counters (stall_cycles, grant_cnt, perf_clr) with ACT_MEM_ARB_PERF_EN.
import act_mem_pkg::*;

module act_mem_ext_arbiter #(
    parameter int unsigned ADDR_W      = ACT_ADDR_W,
    parameter int unsigned DATA_W      = ACT_DATA_W
`ifdef ACT_MEM_ARB_PERF_EN
    ,
    parameter int unsigned STALL_CNT_W = ACT_STALL_CNT_W
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_W-1:0]     rsp_rdata,
    input  logic                  engine_busy,
    input  logic [ADDR_W-1:0]     input_mem_ptr,
    input  logic [ADDR_W-1:0]     output_mem_ptr,
    output logic                  wr_en_ext,
    output logic [ADDR_W-1:0]     wr_addr_ext,
    output logic [DATA_W-1:0]     wr_data_ext,
    output logic                  rd_en_ext,
    output logic [ADDR_W-1:0]     rd_addr_ext,
    input  logic [DATA_W-1:0]     rd_data_ext
`ifdef ACT_MEM_ARB_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned HB = half_msb(ADDR_W);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [1:0]        conflict;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              grant_any;
    req_id_t           grant_id;
    logic              slot_busy;
    logic              rd_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    assign slot_busy = (state != IDLE);

    // Per-port conflict and eligibility; reads also need a free response slot.
    always_comb begin
        conflict = '0;
        eligible = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            conflict[i] = engine_busy &&
                          ((req_addr[i*ADDR_W + HB] == input_mem_ptr[HB]) ||
                           (req_addr[i*ADDR_W + HB] == output_mem_ptr[HB]));
            eligible[i] = reset && req_valid[i] && !conflict[i] &&
                          !(!req_we[i] && slot_busy);
        end
    end

    rr_arbiter_2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .eligible  (eligible),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;
    assign sel_addr  = grant_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = grant_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_we    = grant_id ? req_we[1] : req_we[0];
    assign rd_grant  = grant_any && !sel_we;

    // Drive the memory port in the grant cycle; idle port holds address/data at zero.
    always_comb begin
        wr_en_ext   = 1'b0;
        wr_addr_ext = '0;
        wr_data_ext = '0;
        rd_en_ext   = 1'b0;
        rd_addr_ext = '0;
        if (grant_any) begin
            if (sel_we) begin
                wr_en_ext   = 1'b1;
                wr_addr_ext = sel_addr;
                wr_data_ext = sel_wdata;
            end else begin
                rd_en_ext   = 1'b1;
                rd_addr_ext = sel_addr;
            end
        end
    end

    // Response-slot state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: read grant opens the slot, memory data arrives, response handshake closes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_grant)  state_next = RD_WAIT;
            RD_WAIT:                state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state == RSP);

    // Latch the owner at read grant and the memory data one cycle later; both hold through RSP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE && rd_grant) begin
                rsp_id <= grant_id;
            end
            if (state == RD_WAIT) begin
                rsp_rdata <= rd_data_ext;
            end
        end
    end

`ifdef ACT_MEM_ARB_PERF_EN
    // Saturating perf counters: conflict-stalled cycles and total grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            grant_cnt    <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            grant_cnt    <= '0;
        end else begin
            if (|(req_valid & conflict) && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
            if (grant_any && grant_cnt != '1) begin
                grant_cnt <= grant_cnt + STALL_CNT_W'(1);
            end
        end
    end
`else
    // No performance state in this build; arbitration is unchanged.
`endif

endmodule
